// File: rtl/integrator_pkg.sv
// Shared types and constants for the Euler integrator family: FSM states,
// saturation limits at the default width, and the channel-counter width helper.
package integrator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 18;

    localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    // Never returns less than 1 so a single-channel bank still has a counter bit.
    function automatic int clog2(input int n);
        int r;
        for (r = 1; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/euler_step_alu.sv
// One forward-Euler update: xnext = x + (func >>> dt), with overflow detect.
// Purely combinational, zero latency; no flow control.
module euler_step_alu
    import integrator_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DT_W     = 4,
    parameter int SATURATE = 1
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] func,
    input  logic [DT_W-1:0]  dt,
    output logic [WIDTH-1:0] xnext,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] inc;
    logic [WIDTH:0]   sum;

    always_comb begin
        // Shifts past the word collapse to pure sign fill (0 or -1).
        if (int'(dt) >= WIDTH) begin
            inc = {WIDTH{func[WIDTH-1]}};
        end else begin
            inc = WIDTH'($signed(func) >>> dt);
        end
        sum = {x[WIDTH-1], x} + {inc[WIDTH-1], inc};
        ovf = sum[WIDTH] ^ sum[WIDTH-1];
        if (ovf && (SATURATE != 0)) begin
            xnext = sum[WIDTH] ? NEG_LIM : POS_LIM;
        end else begin
            xnext = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/euler_integrator_bank.sv
// Multi-channel forward-Euler integrator sharing one ALU across all channels.
// Latency CHANNELS+1 cycles from step to done; new step accepted only in IDLE.
module euler_integrator_bank
    import integrator_pkg::*;
#(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 4,
    parameter int DT_W     = 4,
    parameter int SATURATE = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic [CHANNELS*WIDTH-1:0] x_init,
    input  logic [CHANNELS*WIDTH-1:0] func,
    input  logic [DT_W-1:0]           dt,
    input  logic                      step,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*WIDTH-1:0] x_out,
    output logic [CHANNELS-1:0]       ovf
);

    localparam int CW = clog2(CHANNELS);

    state_t                    state, state_nxt;
    logic [CW-1:0]             cnt;
    logic [CHANNELS*WIDTH-1:0] func_cap;
    logic [DT_W-1:0]           dt_cap;
    logic [CHANNELS*WIDTH-1:0] buf_x, commit_x;
    logic [CHANNELS-1:0]       buf_ovf, commit_ovf;
    logic [WIDTH-1:0]          alu_x, alu_f, alu_next;
    logic                      alu_ovf;
    logic                      last;

    assign last  = (cnt == CW'(CHANNELS - 1));
    assign busy  = (state == RUN);
    assign alu_x = x_out[cnt*WIDTH +: WIDTH];
    assign alu_f = func_cap[cnt*WIDTH +: WIDTH];

    euler_step_alu #(
        .WIDTH    (WIDTH),
        .DT_W     (DT_W),
        .SATURATE (SATURATE)
    ) u_alu (
        .x     (alu_x),
        .func  (alu_f),
        .dt    (dt_cap),
        .xnext (alu_next),
        .ovf   (alu_ovf)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (step) state_nxt = RUN;
            RUN:     if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The last channel's result is merged in flight so all channels commit together.
    always_comb begin
        commit_x                       = buf_x;
        commit_x[cnt*WIDTH +: WIDTH]   = alu_next;
        commit_ovf                     = buf_ovf;
        commit_ovf[cnt]                = alu_ovf;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            x_out    <= '0;
            ovf      <= '0;
            done     <= 1'b0;
            func_cap <= '0;
            dt_cap   <= '0;
            buf_x    <= '0;
            buf_ovf  <= '0;
        end else if (load) begin
            state   <= IDLE;
            cnt     <= '0;
            x_out   <= x_init;
            ovf     <= '0;
            done    <= 1'b0;
            buf_ovf <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (state == IDLE && step) begin
                func_cap <= func;
                dt_cap   <= dt;
                cnt      <= '0;
                buf_ovf  <= '0;
            end
            if (state == RUN) begin
                buf_x[cnt*WIDTH +: WIDTH] <= alu_next;
                buf_ovf[cnt]              <= alu_ovf;
                cnt                       <= cnt + CW'(1);
                if (last) begin
                    x_out <= commit_x;
                    ovf   <= ovf | commit_ovf;
                    done  <= 1'b1;
                    cnt   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_euler_integrator_bank.sv
// Directed bench for euler_integrator_bank: saturating main instance plus a
// wrapping instance driven by the same stimulus.
module tb_euler_integrator_bank;

    localparam int W  = 18;
    localparam int CH = 4;
    localparam int DW = 4;

    logic              clock;
    logic              reset;
    logic              load;
    logic [CH*W-1:0]   x_init;
    logic [CH*W-1:0]   func;
    logic [DW-1:0]     dt;
    logic              step;
    logic              busy, busy_w;
    logic              done, done_w;
    logic [CH*W-1:0]   x_out, x_out_w;
    logic [CH-1:0]     ovf, ovf_w;

    int n_vec = 0;
    int n_err = 0;
    int n_done;

    euler_integrator_bank #(.WIDTH(W), .CHANNELS(CH), .DT_W(DW), .SATURATE(1)) dut (
        .clock(clock), .reset(reset), .load(load), .x_init(x_init), .func(func),
        .dt(dt), .step(step), .busy(busy), .done(done), .x_out(x_out), .ovf(ovf)
    );

    euler_integrator_bank #(.WIDTH(W), .CHANNELS(CH), .DT_W(DW), .SATURATE(0)) dut_wrap (
        .clock(clock), .reset(reset), .load(load), .x_init(x_init), .func(func),
        .dt(dt), .step(step), .busy(busy_w), .done(done_w), .x_out(x_out_w), .ovf(ovf_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [CH*W-1:0] pack4(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                              input logic [W-1:0] c2, input logic [W-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [CH*W-1:0] obs, input logic [CH*W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        step   = 1'b1;
        x_init = '0;
        func   = '0;
        dt     = '0;

        // 1: reset dominates a held step
        tick();
        tick();
        check("rst_x", x_out, '0);
        check("rst_ovf", CH*W'(ovf), '0);
        check("rst_busy", CH*W'(busy), '0);
        check("rst_done", CH*W'(done), '0);
        reset = 1'b0;
        step  = 1'b0;

        // 2: basic step with positive and negative derivative
        x_init = pack4(18'h01000, 18'h0, 18'h0, 18'h0);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("load_x", x_out, pack4(18'h01000, 18'h0, 18'h0, 18'h0));
        func = pack4(18'h02000, 18'h3FE00, 18'h0, 18'h0);
        dt   = 4'd9;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t2_busy_c%0d", i), CH*W'({busy, done}), CH*W'(2'b10));
            if (i == 3) check("t2_hold_x", x_out, pack4(18'h01000, 18'h0, 18'h0, 18'h0));
            tick();
        end
        check("t2_done", CH*W'({busy, done}), CH*W'(2'b01));
        check("t2_x", x_out, pack4(18'h01010, 18'h3FFFF, 18'h0, 18'h0));
        tick();
        check("t2_done_pulse", CH*W'(done), '0);

        // 3: positive overflow, saturating vs wrapping
        x_init = pack4(18'h0, 18'h0, 18'h1FFF0, 18'h0);
        load = 1'b1;
        tick();
        load = 1'b0;
        func = pack4(18'h0, 18'h0, 18'h1FFFF, 18'h0);
        dt   = 4'd0;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check("t3_sat_x", x_out, pack4(18'h0, 18'h0, 18'h1FFFF, 18'h0));
        check("t3_sat_ovf", CH*W'(ovf), CH*W'(4'b0100));
        check("t3_wrap_x", x_out_w, pack4(18'h0, 18'h0, 18'h3FFEF, 18'h0));
        check("t3_wrap_ovf", CH*W'(ovf_w), CH*W'(4'b0100));

        // 4: step held high; func change mid-run must not leak into that step
        x_init = '0;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("t4_ovf_clr", CH*W'(ovf), '0);
        func = pack4(18'd1, 18'd2, 18'd3, 18'd4);
        dt   = 4'd0;
        step = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done) n_done++;
            if (i == 5 || i == 10) check($sformatf("t4_done_c%0d", i), CH*W'(done), CH*W'(1));
            if (i == 6) func = pack4(18'h0FFFF, 18'h0FFFF, 18'h0FFFF, 18'h0FFFF);
            if (i == 8) func = pack4(18'd1, 18'd2, 18'd3, 18'd4);
            if (i == 10) check("t4_x2", x_out, pack4(18'd2, 18'd4, 18'd6, 18'd8));
        end
        check("t4_ndone", CH*W'(n_done), CH*W'(2));
        step = 1'b0;
        tick();
        tick();
        tick();
        check("t4_done3", CH*W'(done), CH*W'(1));
        check("t4_x3", x_out, pack4(18'd3, 18'd6, 18'd9, 18'd12));

        // 5: load aborts a running step
        func = pack4(18'h00100, 18'h0, 18'h0, 18'h0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        x_init = pack4(18'h00123, 18'h0, 18'h0, 18'h0);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("t5_x", x_out, pack4(18'h00123, 18'h0, 18'h0, 18'h0));
        check("t5_busy", CH*W'({busy, done}), '0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) n_done++;
        end
        check("t5_no_done", CH*W'(n_done), '0);
        check("t5_x_kept", x_out, pack4(18'h00123, 18'h0, 18'h0, 18'h0));

        // 6: large shift, positive rounds to 0, negative to -1
        x_init = pack4(18'h0, 18'h0, 18'h0, 18'h00050);
        load = 1'b1;
        tick();
        load = 1'b0;
        func = pack4(18'h0, 18'h0, 18'h0, 18'h00100);
        dt   = 4'd15;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check("t6_pos", x_out, pack4(18'h0, 18'h0, 18'h0, 18'h00050));
        func = pack4(18'h0, 18'h0, 18'h0, 18'h3FF00);
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check("t6_neg", x_out, pack4(18'h0, 18'h0, 18'h0, 18'h0004F));
        check("t6_ovf", CH*W'(ovf), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
